// File: rtl/lsu_pkg.sv
// Shared memory-op encodings, LSU state codes and op-class helpers.
package lsu_pkg;
  localparam int DATA_WIDTH_MEM_OP = 4;

  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LH   = 4'd2;
  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LW   = 4'd3;
  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LBU  = 4'd4;
  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LHU  = 4'd5;
  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SB   = 4'd6;
  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SH   = 4'd7;
  localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SW   = 4'd8;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_REQ  = 1'b1
  } lsu_state_e;

  function automatic logic op_is_load(input logic [DATA_WIDTH_MEM_OP-1:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [DATA_WIDTH_MEM_OP-1:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobes/replication, alignment check,
// and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misalign,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);
  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misalign = 1'b0;
    wstrb    = 4'b0000;
    wdata    = st_data;
    case (st_op)
      MEM_OP_LH, MEM_OP_LHU: misalign = st_off[0];
      MEM_OP_LW:             misalign = |st_off;
      MEM_OP_SB: begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      MEM_OP_SH: begin
        misalign = st_off[0];
        wstrb    = 4'b0011 << st_off;
        wdata    = {2{st_data[15:0]}};
      end
      MEM_OP_SW: begin
        misalign = |st_off;
        wstrb    = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift = rdata >> {ld_off, 3'b000};
    ld_byte  = ld_shift[7:0];
    ld_half  = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_op)
      MEM_OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_OP_LBU: ld_data = {24'd0, ld_byte};
      MEM_OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_OP_LHU: ld_data = {16'd0, ld_half};
      default:    ld_data = rdata;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: two-state bus FSM (IDLE/REQ) with registered bus and
// writeback outputs; a flush during REQ lets the transfer finish but kills writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_mem_op,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_gpr_we,
  input  logic              flush,
  output logic              lsu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_gpr_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_misalign
);
  lsu_state_e  state_q, state_d;
  logic        kill_q, kill_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d, op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic        gpr_we_q, gpr_we_d;
  logic        wb_valid_q, wb_valid_d, wb_gpr_we_q, wb_gpr_we_d, wb_mis_q, wb_mis_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_ld_data;
  logic        al_mis, ex_ld, ex_st;

  // Store side looks at the incoming op; load side at the op held for the transfer.
  lsu_align u_align (
    .st_op   (ex_mem_op),
    .st_off  (ex_alu_out[1:0]),
    .st_data (ex_store_data),
    .wstrb   (al_wstrb),
    .wdata   (al_wdata),
    .misalign(al_mis),
    .ld_op   (op_q),
    .ld_off  (off_q),
    .rdata   (mem_rdata),
    .ld_data (al_ld_data)
  );

  assign ex_ld = op_is_load(ex_mem_op);
  assign ex_st = op_is_store(ex_mem_op);

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    op_d        = op_q;
    off_d       = off_q;
    rd_d        = rd_q;
    gpr_we_d    = gpr_we_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_gpr_we_d = wb_gpr_we_q;
    wb_data_d   = wb_data_q;
    wb_mis_d    = wb_mis_q;
    case (state_q)
      LSU_IDLE: begin
        if (ex_valid && !flush) begin
          if ((ex_ld || ex_st) && al_mis) begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = ex_rd;
            wb_gpr_we_d = 1'b0;
            wb_data_d   = ex_alu_out;
            wb_mis_d    = 1'b1;
          end else if (ex_ld || ex_st) begin
            state_d     = LSU_REQ;
            kill_d      = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_st;
            mem_addr_d  = {ex_alu_out[31:2], 2'b00};
            mem_wstrb_d = al_wstrb;
            mem_wdata_d = ex_st ? al_wdata : 32'd0;
            op_d        = ex_mem_op;
            off_d       = ex_alu_out[1:0];
            rd_d        = ex_rd;
            gpr_we_d    = ex_gpr_we;
          end else begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = ex_rd;
            wb_gpr_we_d = ex_gpr_we;
            wb_data_d   = ex_alu_out;
            wb_mis_d    = 1'b0;
          end
        end
      end
      LSU_REQ: begin
        if (flush) kill_d = 1'b1;
        if (mem_ready) begin
          state_d   = LSU_IDLE;
          kill_d    = 1'b0;
          mem_req_d = 1'b0;
          if (!(kill_q || flush)) begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = rd_q;
            wb_mis_d    = 1'b0;
            wb_gpr_we_d = mem_we_q ? 1'b0 : gpr_we_q;
            if (!mem_we_q) wb_data_d = al_ld_data;
          end
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wstrb_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      op_q        <= MEM_OP_NONE;
      off_q       <= 2'd0;
      rd_q        <= 5'd0;
      gpr_we_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_gpr_we_q <= 1'b0;
      wb_data_q   <= 32'd0;
      wb_mis_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      gpr_we_q    <= gpr_we_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_gpr_we_q <= wb_gpr_we_d;
      wb_data_q   <= wb_data_d;
      wb_mis_q    <= wb_mis_d;
    end
  end

  assign lsu_stall   = (state_q == LSU_REQ);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_gpr_we   = wb_gpr_we_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_mis_q;
endmodule

// File: tb/tb_lsu.sv
// Directed vector bench for lsu: table of ops with hand-computed results,
// plus hand sequences for flush, reset-in-REQ and hold behaviour.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_gpr_we = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic [3:0]  ex_mem_op = 4'd0;
  logic [31:0] ex_alu_out = 32'd0, ex_store_data = 32'd0, mem_rdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        lsu_stall, mem_req, mem_we, wb_valid, wb_gpr_we, wb_misalign;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rd;

  int checks = 0, errors = 0;

  lsu #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_gpr_we(ex_gpr_we), .flush(flush), .lsu_stall(lsu_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_gpr_we(wb_gpr_we), .wb_data(wb_data), .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          dly;
    logic        mis;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] wb_dat;
    logic        wb_we;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_op = op; ex_alu_out = alu; ex_store_data = sd;
    ex_rd = rd; ex_gpr_we = 1'b1;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_mem_op = MEM_OP_NONE;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, {31'd0, lsu_stall}, 32'd0);
    chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, " mem_bus"}, {mem_addr | mem_wdata}, 32'd0);
    chk({tag, " mem_ctl"}, {27'd0, mem_we, mem_wstrb}, 32'd0);
    chk({tag, " wb_ctl"}, {24'd0, wb_valid, wb_gpr_we, wb_misalign, wb_rd}, 32'd0);
    chk({tag, " wb_data"}, wb_data, 32'd0);
  endtask

  task automatic none_op(input string tag);
    drive(MEM_OP_NONE, 32'h5, 32'd0, 5'd3);
    tick();
    idle_in();
    chk({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, " wb_data"}, wb_data, 32'h5);
    chk({tag, " wb_rd"}, {27'd0, wb_rd}, 32'd3);
    chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    //        op           alu           sdata         rdata         rd  dly mis wstrb    wdata         we    wb_data       wb_we
    vt[0]  = '{MEM_OP_NONE, 32'h00000005, 32'h0,        32'h0,        5'd3, 0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h00000005, 1'b1};
    vt[1]  = '{MEM_OP_LB,   32'h00001003, 32'h0,        32'h80112233, 5'd4, 2, 1'b0, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
    vt[2]  = '{MEM_OP_SH,   32'h00002002, 32'h1234ABCD, 32'h0,        5'd5, 0, 1'b0, 4'b1100, 32'hABCDABCD, 1'b1, 32'hFFFFFF80, 1'b0};
    vt[3]  = '{MEM_OP_LW,   32'h00003001, 32'h0,        32'h0,        5'd6, 0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h00003001, 1'b0};
    vt[4]  = '{MEM_OP_LBU,  32'h00001002, 32'h0,        32'h80112233, 5'd7, 1, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h00000011, 1'b1};
    vt[5]  = '{MEM_OP_LH,   32'h00001002, 32'h0,        32'h80112233, 5'd8, 0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'hFFFF8011, 1'b1};
    vt[6]  = '{MEM_OP_LHU,  32'h00001000, 32'h0,        32'h80112233, 5'd9, 0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h00002233, 1'b1};
    vt[7]  = '{MEM_OP_LW,   32'h00001004, 32'h0,        32'hDEADBEEF, 5'd10, 1, 1'b0, 4'b0000, 32'h0,       1'b0, 32'hDEADBEEF, 1'b1};
    vt[8]  = '{MEM_OP_SB,   32'h00002001, 32'h000000A5, 32'h0,        5'd11, 0, 1'b0, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[9]  = '{MEM_OP_SW,   32'h00002000, 32'hCAFEF00D, 32'h0,        5'd12, 1, 1'b0, 4'b1111, 32'hCAFEF00D, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[10] = '{MEM_OP_SH,   32'h00002001, 32'h0000BEEF, 32'h0,        5'd13, 0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h00002001, 1'b0};
    vt[11] = '{MEM_OP_LHU,  32'h00001003, 32'h0,        32'h0,        5'd14, 0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h00001003, 1'b0};

    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      string tg;
      tg = $sformatf("v%0d", i);
      drive(vt[i].op, vt[i].alu, vt[i].sdata, vt[i].rd);
      tick();
      if (vt[i].op == MEM_OP_NONE || vt[i].mis) begin
        idle_in();
        chk({tg, " mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tg, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tg, " wb_mis"}, {31'd0, wb_misalign}, {31'd0, vt[i].mis});
      end else begin
        chk({tg, " mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tg, " stall"}, {31'd0, lsu_stall}, 32'd1);
        chk({tg, " wb_valid0"}, {31'd0, wb_valid}, 32'd0);
        chk({tg, " addr"}, mem_addr, {vt[i].alu[31:2], 2'b00});
        chk({tg, " we/strb"}, {27'd0, mem_we, mem_wstrb}, {27'd0, vt[i].we, vt[i].wstrb});
        if (vt[i].we) chk({tg, " wdata"}, mem_wdata, vt[i].wdata);
        for (int d = 0; d < vt[i].dly; d++) begin
          tick();
          chk({tg, " hold req"}, {31'd0, mem_req & lsu_stall}, 32'd1);
          chk({tg, " hold addr"}, mem_addr, {vt[i].alu[31:2], 2'b00});
        end
        mem_ready = 1'b1; mem_rdata = vt[i].rdata;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'd0;
        idle_in();
        chk({tg, " req done"}, {30'd0, mem_req, lsu_stall}, 32'd0);
        chk({tg, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tg, " wb_mis"}, {31'd0, wb_misalign}, 32'd0);
      end
      chk({tg, " wb_data"}, wb_data, vt[i].wb_dat);
      chk({tg, " wb_rd"}, {27'd0, wb_rd}, {27'd0, vt[i].rd});
      chk({tg, " wb_gpr_we"}, {31'd0, wb_gpr_we}, {31'd0, vt[i].wb_we});
    end

    // Idle cycle with stray mem_ready: no pulse, writeback fields hold.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("hold wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("hold wb_data", wb_data, 32'h00001003);
    chk("hold wb_rd", {27'd0, wb_rd}, 32'd14);
    chk("stray ready req", {31'd0, mem_req}, 32'd0);

    // Flush in IDLE suppresses acceptance.
    drive(MEM_OP_LW, 32'h00004000, 32'd0, 5'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; idle_in();
    chk("flush idle req", {31'd0, mem_req}, 32'd0);
    chk("flush idle wb", {31'd0, wb_valid}, 32'd0);

    // Flush in first REQ cycle; transfer still completes, no writeback.
    drive(MEM_OP_LW, 32'h00001008, 32'd0, 5'd2);
    tick();
    chk("kill req", {31'd0, mem_req}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("kill not aborted", {31'd0, mem_req & lsu_stall}, 32'd1);
    chk("kill addr", mem_addr, 32'h00001008);
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ready = 1'b0; idle_in();
    chk("kill done", {30'd0, mem_req, lsu_stall}, 32'd0);
    chk("kill wb", {31'd0, wb_valid}, 32'd0);
    chk("kill wb_data", wb_data, 32'h00001003);
    tick();
    chk("kill wb late", {31'd0, wb_valid}, 32'd0);
    // Kill flag must not leak into the next transfer.
    drive(MEM_OP_LBU, 32'h00001001, 32'd0, 5'd20);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h80112233;
    tick();
    mem_ready = 1'b0; idle_in();
    chk("post kill wb", {31'd0, wb_valid}, 32'd1);
    chk("post kill data", wb_data, 32'h00000022);

    // Flush together with mem_ready.
    drive(MEM_OP_LW, 32'h0000100C, 32'd0, 5'd2);
    tick();
    flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h22222222;
    tick();
    flush = 1'b0; mem_ready = 1'b0; idle_in();
    chk("flush+ready idle", {30'd0, mem_req, lsu_stall}, 32'd0);
    chk("flush+ready wb", {31'd0, wb_valid}, 32'd0);

    // Reset in mid-REQ abandons the transfer.
    drive(MEM_OP_SW, 32'h00002004, 32'h55AA55AA, 5'd9);
    tick();
    chk("pre rst req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; idle_in();
    chk_all_zero("rst req");
    tick();
    chk("rst no wb", {31'd0, wb_valid}, 32'd0);
    none_op("after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set GPR, address and bus data width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, SHALL be synchronous and active-low.
REQ-004 ex_valid  in  1  execute stage presents an op this cycle.
REQ-005 ex_mem_op  in  4  MEM_OP_* code: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-006 ex_alu_out  in  32  ALU result; this is the effective address for memory ops.
REQ-007 ex_store_data  in  32  rs2 value for stores.
REQ-008 ex_rd  in  5  destination register.
REQ-009 ex_gpr_we  in  1  destination write enable.
REQ-010 flush  in  1  kill the current and in-flight op.
REQ-011 lsu_stall  out  1  upstream SHALL hold its ex_* signals while this is high.
REQ-012 mem_req  out  1  bus request.
REQ-013 mem_we  out  1  1 = store.
REQ-014 mem_addr  out  32  word-aligned address, {ex_alu_out[31:2],2'b00}.
REQ-015 mem_wstrb  out  4  byte write strobes.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_ready  in  1  bus completes the transfer this cycle.
REQ-018 mem_rdata  in  32  load data, valid when mem_ready=1.
REQ-019 wb_valid  out  1  one-cycle pulse: writeback fields are valid.
REQ-020 wb_rd, wb_gpr_we, wb_data, wb_misalign  out  5/1/32/1  writeback fields; wb_misalign flags a misaligned access.

Function
REQ-021 The FSM SHALL have two states, IDLE and REQ; lsu_stall SHALL equal (state==REQ) and be combinational.
REQ-022 IDLE, ex_valid=1, flush=0, op=NONE: the next cycle SHALL show wb_valid=1, wb_data=ex_alu_out, and wb_rd/wb_gpr_we passed through (1-cycle latency).
REQ-023 IDLE, aligned load or store: the block SHALL register addr, we, wstrb and wdata and go to REQ; mem_req=1 from the next cycle; wb_valid=0 that cycle.
REQ-024 In REQ, mem_req, mem_addr, mem_we, mem_wstrb and mem_wdata SHALL hold stable until the cycle mem_ready=1.
REQ-025 In REQ with mem_ready=1: the block SHALL return to IDLE and deassert mem_req next cycle; wb_valid=1 next cycle unless killed.
REQ-026 The earliest next op acceptance SHALL be the cycle after mem_ready; minimum memory-op latency is 2 cycles (accept, then REQ with mem_ready).
REQ-027 Alignment: LH/LHU/SH SHALL require addr[0]=0; LW/SW SHALL require addr[1:0]=00.
REQ-028 A misaligned op SHALL issue no bus request; next cycle wb_valid=1, wb_misalign=1, wb_gpr_we=0, wb_data=effective address.
REQ-029 Loads SHALL select the byte by addr[1:0] and the halfword by addr[1]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, LW SHALL pass the word through.
REQ-030 Stores: SB SHALL drive wstrb=0001<<addr[1:0] and wdata={4{byte}}; SH SHALL drive wstrb=0011<<addr[1:0] and wdata={2{half}}; SW SHALL drive wstrb=1111.
REQ-031 Store completion SHALL pulse wb_valid with wb_gpr_we=0; all loads SHALL use wb_gpr_we=ex_gpr_we.
REQ-032 flush in IDLE SHALL suppress acceptance: no request is issued and wb_valid=0 next cycle.
REQ-033 flush in REQ SHALL set a kill flag; the bus transfer SHALL still complete and SHALL NOT be aborted; wb_valid SHALL stay 0 for it; the kill flag SHALL clear on return to IDLE.
REQ-034 flush and mem_ready in the same REQ cycle SHALL complete the transfer, suppress writeback, and return to IDLE.
REQ-035 mem_ready outside REQ SHALL be ignored; ex_* SHALL be ignored in REQ.
REQ-036 When wb_valid=0, the other wb_* fields SHALL retain their previous values.

Reset
REQ-037 On rst_n=0 at a clock edge: state SHALL go to IDLE, the kill flag SHALL clear, and all outputs SHALL go to 0, except lsu_stall, which is 0 by REQ-021.
REQ-038 Reset during REQ SHALL abandon the transfer; mem_req=0 the next cycle and no writeback SHALL occur.

Structure
REQ-039 MEM_OP_* encodings (NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8), DATA_WIDTH_MEM_OP=4 and the LSU state codes SHALL live in the shared define file.
REQ-040 Lane extraction and strobe/data generation SHALL be one combinational sub-module, lsu_align; the FSM and registers SHALL stay in lsu.

Verification
REQ-041 The bench SHALL cover: op=NONE, alu_out=0x00000005, rd=3 -> next cycle wb_valid=1, wb_data=0x00000005, wb_rd=3, mem_req=0 throughout.
REQ-042 The bench SHALL cover: LB at 0x00001003, mem_ready after 2 REQ cycles, rdata=0x80112233 -> mem_addr=0x00001000, lsu_stall high during REQ, wb_data=0xFFFFFF80.
REQ-043 The bench SHALL cover: SH at 0x00002002, store_data=0x1234ABCD -> wstrb=1100, wdata=0xABCDABCD, mem_we=1, wb_gpr_we=0.
REQ-044 The bench SHALL cover: LW at 0x00003001 -> no mem_req, next cycle wb_misalign=1, wb_data=0x00003001.
REQ-045 The bench SHALL cover: LW in REQ, flush in the first REQ cycle, mem_ready 1 cycle later -> transfer completes, wb_valid stays 0, state returns to IDLE.
REQ-046 The bench SHALL cover: rst_n=0 in mid-REQ -> mem_req=0 and all outputs 0 next cycle; a later NONE op then behaves as in REQ-041.
